// File: rtl/segre_pkg.sv
// segre_pkg: shared core constants plus branch-controller state and alignment definitions.
package segre_pkg;

    localparam int WORD_SIZE = 32;
    localparam int BR_STAT_W = 32;
    localparam logic [1:0] PC_ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {BR_IDLE, BR_DRAIN, BR_REDIRECT} br_ctrl_state_e;

endpackage

// File: rtl/segre_br_stats.sv
// segre_br_stats: three saturating event counters for the branch controller.
module segre_br_stats #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_resolved_i,
    input  logic         inc_taken_i,
    input  logic         inc_flush_i,
    output logic [W-1:0] resolved_o,
    output logic [W-1:0] taken_o,
    output logic [W-1:0] flush_cyc_o
);

    logic [W-1:0] r_resolved, r_taken, r_flush;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_resolved <= '0;
            r_taken    <= '0;
            r_flush    <= '0;
        end else begin
            if (inc_resolved_i && !(&r_resolved)) r_resolved <= r_resolved + 1'b1;
            if (inc_taken_i && !(&r_taken)) r_taken <= r_taken + 1'b1;
            if (inc_flush_i && !(&r_flush)) r_flush <= r_flush + 1'b1;
        end
    end

    assign resolved_o  = r_resolved;
    assign taken_o     = r_taken;
    assign flush_cyc_o = r_flush;

endmodule

// File: rtl/segre_branch_ctrl.sv
// segre_branch_ctrl: squashes IF/ID on a taken branch, drains fetch, then issues one PC redirect.
// Statistics counters are present only when SEGRE_BR_STATS_EN is defined.
module segre_branch_ctrl #(
    parameter int WORD_SIZE = segre_pkg::WORD_SIZE,
    parameter int STAT_W    = segre_pkg::BR_STAT_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ex_br_valid_i,
    input  logic                 ex_tkbr_i,
    input  logic [WORD_SIZE-1:0] ex_target_i,
    input  logic                 ex_stall_i,
    input  logic                 if_busy_i,
    input  logic                 if_rsp_valid_i,
    input  logic                 if_ready_i,
    output logic                 flush_if_o,
    output logic                 flush_id_o,
    output logic                 drop_rsp_o,
    output logic                 pc_redirect_o,
    output logic [WORD_SIZE-1:0] pc_target_o,
    output logic                 br_busy_o,
    output logic                 misaligned_o,
    output logic [STAT_W-1:0]    stat_resolved_o,
    output logic [STAT_W-1:0]    stat_taken_o,
    output logic [STAT_W-1:0]    stat_flush_cyc_o
);

    import segre_pkg::*;

    br_ctrl_state_e       r_state, w_next;
    logic [WORD_SIZE-1:0] r_target;
    logic                 w_accept, w_taken, w_misaligned, w_go;

    assign w_accept     = (r_state == BR_IDLE) && ex_br_valid_i && !ex_stall_i;
    assign w_taken      = w_accept && ex_tkbr_i;
    assign w_misaligned = w_taken && |(ex_target_i[1:0] & PC_ALIGN_MASK);
    assign w_go         = w_taken && !w_misaligned;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= BR_IDLE;
            r_target <= '0;
        end else begin
            r_state <= w_next;
            if (w_go) r_target <= ex_target_i;
        end
    end

    always_comb begin
        w_next = (r_state == BR_IDLE)  ? (w_go ? (if_busy_i ? BR_DRAIN : BR_REDIRECT) : BR_IDLE) :
                 (r_state == BR_DRAIN) ? (if_rsp_valid_i ? BR_REDIRECT : BR_DRAIN) :
                                         (if_ready_i ? BR_IDLE : BR_REDIRECT);
    end

    // A response coinciding with the accepting cycle is dropped together with the flush.
    always_comb begin
        flush_if_o    = w_go || (r_state != BR_IDLE);
        flush_id_o    = w_go;
        drop_rsp_o    = (r_state == BR_DRAIN) || (w_go && if_busy_i && if_rsp_valid_i);
        pc_redirect_o = (r_state == BR_REDIRECT);
        pc_target_o   = (r_state == BR_REDIRECT) ? r_target : '0;
        br_busy_o     = (r_state != BR_IDLE);
        misaligned_o  = w_misaligned;
    end

`ifdef SEGRE_BR_STATS_EN
    segre_br_stats #(.W(STAT_W)) u_stats (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .inc_resolved_i (w_accept),
        .inc_taken_i    (w_taken),
        .inc_flush_i    (flush_if_o),
        .resolved_o     (stat_resolved_o),
        .taken_o        (stat_taken_o),
        .flush_cyc_o    (stat_flush_cyc_o)
    );
`else
    assign stat_resolved_o  = '0;
    assign stat_taken_o     = '0;
    assign stat_flush_cyc_o = '0;
`endif

endmodule

// File: tb/tb_segre_branch_ctrl.sv
// tb_segre_branch_ctrl: directed bench with a per-cycle reference model of the branch controller.
module tb_segre_branch_ctrl;

`ifdef SEGRE_BR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam int SW  = 4;
    localparam int SAT = 15;

    logic        clk = 0, rst = 1;
    logic        valid = 0, tkbr = 0, stall = 0, busy = 0, rsp = 0, ready = 0;
    logic [31:0] tgt = 0;
    logic        flush_if, flush_id, drop, redir, br_busy, mis;
    logic [31:0] pc_tgt;
    logic [SW-1:0] s_res, s_tak, s_fl;

    int errors = 0, checks = 0;
    bit chk_en = 0;

    segre_branch_ctrl #(.WORD_SIZE(32), .STAT_W(SW)) dut (
        .clk_i(clk), .rst_i(rst), .ex_br_valid_i(valid), .ex_tkbr_i(tkbr),
        .ex_target_i(tgt), .ex_stall_i(stall), .if_busy_i(busy),
        .if_rsp_valid_i(rsp), .if_ready_i(ready), .flush_if_o(flush_if),
        .flush_id_o(flush_id), .drop_rsp_o(drop), .pc_redirect_o(redir),
        .pc_target_o(pc_tgt), .br_busy_o(br_busy), .misaligned_o(mis),
        .stat_resolved_o(s_res), .stat_taken_o(s_tak), .stat_flush_cyc_o(s_fl)
    );

    always #5 clk = ~clk;

    // Model: a redirect is owed (pending), optionally still waiting on a fetch response.
    bit        m_pend = 0, m_drain = 0;
    logic [31:0] m_tgt = 0;
    int        m_res = 0, m_tak = 0, m_fl = 0;
    bit        e_acc, e_tk, e_mis, e_go, e_fif, e_fid, e_drop, e_redir;

    always_comb begin
        e_acc   = !m_pend && valid && !stall;
        e_tk    = e_acc && tkbr;
        e_mis   = e_tk && (tgt % 4 != 0);
        e_go    = e_tk && !e_mis;
        e_fif   = e_go || m_pend;
        e_fid   = e_go;
        e_drop  = (m_pend && m_drain) || (e_go && busy && rsp);
        e_redir = m_pend && !m_drain;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_pend <= 0; m_drain <= 0; m_tgt <= 0; m_res <= 0; m_tak <= 0; m_fl <= 0;
        end else begin
            if (e_go) begin
                m_pend <= 1; m_drain <= busy; m_tgt <= tgt;
            end else if (m_pend && m_drain && rsp) m_drain <= 0;
            else if (m_pend && !m_drain && ready) m_pend <= 0;
            m_res <= (e_acc && m_res < SAT) ? m_res + 1 : m_res;
            m_tak <= (e_tk && m_tak < SAT) ? m_tak + 1 : m_tak;
            m_fl  <= (e_fif && m_fl < SAT) ? m_fl + 1 : m_fl;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("m_flush_if", flush_if, e_fif);
            chk("m_flush_id", flush_id, e_fid);
            chk("m_drop", drop, e_drop);
            chk("m_redirect", redir, e_redir);
            chk("m_target", pc_tgt, e_redir ? m_tgt : 32'h0);
            chk("m_busy", br_busy, m_pend);
            chk("m_misaligned", mis, e_mis);
            chk("m_stat_res", s_res, STATS ? m_res : 0);
            chk("m_stat_tak", s_tak, STATS ? m_tak : 0);
            chk("m_stat_fl", s_fl, STATS ? m_fl : 0);
        end
    end

    task automatic drive(input bit v, input bit t, input logic [31:0] a, input bit st,
                         input bit b, input bit r, input bit rd);
        valid = v; tkbr = t; tgt = a; stall = st; busy = b; rsp = r; ready = rd;
        @(negedge clk);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1;
        drive(0, 0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0); step();
        rst = 0;
    endtask

    initial begin
        do_reset();
        chk_en = 1;
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("rst_flush_if", flush_if, 0); chk("rst_redirect", redir, 0);
        chk("rst_busy", br_busy, 0); chk("rst_target", pc_tgt, 0); step();

        // Taken, fetch idle
        drive(1, 1, 32'h100, 0, 0, 0, 1);
        chk("t1_flush_if_N", flush_if, 1); chk("t1_flush_id_N", flush_id, 1);
        chk("t1_redir_N", redir, 0); step();
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("t1_redir_N1", redir, 1); chk("t1_target_N1", pc_tgt, 32'h100);
        chk("t1_busy_N1", br_busy, 1); step();
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("t1_idle_N2", br_busy, 0); chk("t1_redir_N2", redir, 0); step();

        // Taken, fetch busy, response at N+3
        drive(1, 1, 32'h200, 0, 1, 0, 1);
        chk("t2_drop_N", drop, 0); chk("t2_flush_N", flush_if, 1); step();
        for (int i = 1; i <= 3; i++) begin
            drive(0, 0, 0, 0, 1, i == 3, 1);
            chk("t2_drop_drain", drop, 1); chk("t2_redir_drain", redir, 0); step();
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("t2_redir_N4", redir, 1); chk("t2_target_N4", pc_tgt, 32'h200);
        chk("t2_drop_N4", drop, 0); step();
        drive(0, 0, 0, 0, 0, 0, 1); step();

        // Redirect backpressure
        drive(1, 1, 32'h300, 0, 0, 0, 0); step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 32'h400, 0, 0, 0, 0);
            chk("t3_redir_hold", redir, 1); chk("t3_target_hold", pc_tgt, 32'h300);
            chk("t3_busy_hold", br_busy, 1); step();
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("t3_redir_ready", redir, 1); chk("t3_target_ready", pc_tgt, 32'h300); step();
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("t3_busy_after", br_busy, 0); step();

        // Not taken and misaligned
        do_reset();
        drive(1, 0, 32'h500, 0, 0, 0, 1);
        chk("t4_nt_flush", flush_if, 0); step();
        drive(1, 1, 32'h102, 0, 0, 0, 1);
        chk("t4_mis_pulse", mis, 1); chk("t4_mis_flush", flush_if, 0); step();
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("t4_mis_once", mis, 0); chk("t4_mis_noredir", redir, 0);
        chk("t4_stat_res", s_res, STATS ? 2 : 0); chk("t4_stat_tak", s_tak, STATS ? 1 : 0); step();

        // Simultaneous busy and response at the accept cycle
        drive(1, 1, 32'h600, 0, 1, 1, 1);
        chk("t5_sim_drop", drop, 1); step();
        drive(0, 0, 0, 0, 1, 0, 1); chk("t5_sim_drain", drop, 1); step();
        drive(0, 0, 0, 0, 1, 1, 1); step();
        drive(0, 0, 0, 0, 0, 0, 1); chk("t5_sim_redir", pc_tgt, 32'h600); step();
        drive(0, 0, 0, 0, 0, 0, 1); step();

        // Stall ignored, then reset during DRAIN
        drive(1, 1, 32'h700, 1, 0, 0, 1);
        chk("t6_stall_flush", flush_if, 0); step();
        drive(0, 0, 0, 0, 0, 0, 1); chk("t6_stall_busy", br_busy, 0); step();
        drive(1, 1, 32'h800, 0, 1, 0, 1); step();
        rst = 1;
        drive(0, 0, 0, 0, 1, 0, 1); step();
        rst = 0;
        drive(0, 0, 0, 0, 1, 0, 1);
        chk("t6_rst_busy", br_busy, 0); chk("t6_rst_flush", flush_if, 0);
        chk("t6_rst_drop", drop, 0); chk("t6_rst_redir", redir, 0); step();

        // Counter saturation
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 0, 0, 0, 1); step();
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("t7_sat_res", s_res, STATS ? 15 : 0); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/segre_branch_ctrl.md
# segre_branch_ctrl

Control sequencer for taken branches and jumps. Consumes the resolved branch outcome of the EX stage (taken flag plus target), squashes younger instructions in IF/ID, drains any in-flight instruction fetch, then issues a single PC redirect to the fetch unit under a valid/ready handshake. Sits between the EX stage and the fetch/PC logic in `segre_core`.

## Interface
Parameters:
- `WORD_SIZE`, 32 (from `segre_pkg`): address/target width.
- `STAT_W`, 32: width of each statistics counter.

Ports:
- `clk_i`  in  1  core clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `ex_br_valid_i`  in  1  EX holds a resolved branch/jump this cycle.
- `ex_tkbr_i`  in  1  branch taken; jumps always 1.
- `ex_target_i`  in  WORD_SIZE  branch/jump target address.
- `ex_stall_i`  in  1  EX is stalled; the resolution is not yet final.
- `if_busy_i`  in  1  fetch has an outstanding memory request.
- `if_rsp_valid_i`  in  1  fetch memory response returns this cycle.
- `if_ready_i`  in  1  fetch accepts a redirect.
- `flush_if_o`  out  1  kill the IF stage contents.
- `flush_id_o`  out  1  kill the ID stage contents.
- `drop_rsp_o`  out  1  discard the fetch response arriving this cycle.
- `pc_redirect_o`  out  1  redirect valid.
- `pc_target_o`  out  WORD_SIZE  redirect address.
- `br_busy_o`  out  1  controller is not idle; hold EX.
- `misaligned_o`  out  1  one-cycle pulse: the target is not 4-byte aligned.
- `stat_resolved_o`, `stat_taken_o`, `stat_flush_cyc_o`  out  STAT_W  statistics counters.

## Operation
- The FSM has three states: IDLE, DRAIN, REDIRECT.
- **Accept condition.** A resolution is accepted in IDLE when `ex_br_valid_i && !ex_stall_i`.
- **IDLE, not taken.** No action; only the statistics counters update.
- **IDLE, taken, target[1:0]!=0.**
  - Pulse `misaligned_o` for that cycle.
  - No flush and no redirect; stay in IDLE.
- **IDLE, taken, aligned.**
  - Assert `flush_if_o` and `flush_id_o` combinationally in the same cycle.
  - Latch `ex_target_i` into the target register.
  - Next state is DRAIN if `if_busy_i`, else REDIRECT.
- **DRAIN.**
  - Hold `flush_if_o=1` and `drop_rsp_o=1`.
  - On `if_rsp_valid_i`, that response is dropped and the next state is REDIRECT.
- **REDIRECT.**
  - Hold `flush_if_o=1` and `pc_redirect_o=1`, with `pc_target_o` = latched target.
  - On `if_ready_i`, return to IDLE.
  - `pc_redirect_o` must stay high and the target must stay stable until `if_ready_i`.
- **Non-IDLE states.**
  - `br_busy_o=1`.
  - `ex_br_valid_i` is ignored; EX is held by `br_busy_o`, so no resolution is lost.
- **Simultaneous events.**
  - In IDLE with `if_busy_i` and `if_rsp_valid_i` both 1 on the resolution cycle, go to DRAIN.
  - The concurrent response is dropped in that same cycle: `drop_rsp_o` is asserted combinationally with the flush.
- **Outside DRAIN.** `drop_rsp_o` is 0 except in the simultaneous case above.

## Timing
- **Reset values.** All outputs 0; state IDLE; target register 0; counters 0.
- **Mid-operation reset.** Reset in DRAIN or REDIRECT aborts the operation; the next cycle is IDLE with all outputs 0.
- **Flush latency.** 0 cycles from the accepted taken resolution (cycle N).
- **Redirect latency.** The earliest `pc_redirect_o` is cycle N+1, when `if_busy_i=0` at N.
  - With a drain, the redirect comes one cycle after the `if_rsp_valid_i` cycle.
- **Minimum occupancy.** A taken branch holds `br_busy_o` for at least 1 cycle (N+1) when `if_ready_i=1` at N+1.
- **Back-to-back branches.** The next accept is possible in the cycle after the handshake completes.

## Configuration
- **With `SEGRE_BR_STATS_EN` defined:**
  - `stat_resolved_o` increments on every accepted resolution.
  - `stat_taken_o` increments on every accepted taken resolution, including misaligned ones.
  - `stat_flush_cyc_o` increments on every cycle where `flush_if_o=1`.
  - All three saturate at all-ones; they are cleared only by reset.
- **Without the macro:** the ports remain but are tied to 0, and no counter flops are present.

## Structure
- `segre_pkg` gains:
  - `br_ctrl_state_e` (`BR_IDLE`, `BR_DRAIN`, `BR_REDIRECT`);
  - `BR_STAT_W`;
  - the constant `PC_ALIGN_MASK = 2'b11`.
- The sub-module `segre_br_stats` holds the three saturating counters.
  - It is instantiated only under `SEGRE_BR_STATS_EN`.
  - Its inputs are `clk_i`, `rst_i` and the three increment strobes.

## Test plan
- **Taken, fetch idle.** Reset, then `ex_br_valid_i=1`, `ex_tkbr_i=1`, target `0x0000_0100`, `if_busy_i=0`, `if_ready_i=1`.
  - Flushes at N.
  - `pc_redirect_o=1` with target `0x100` at N+1.
  - IDLE at N+2.
- **Taken, fetch busy.** Target `0x200`, `if_busy_i=1`, `if_rsp_valid_i` arriving at N+3.
  - `drop_rsp_o` high N+1..N+3.
  - Redirect at N+4.
- **Redirect backpressure.** `if_ready_i=0` for 3 cycles.
  - `pc_redirect_o` and target `0x300` stay stable.
  - `br_busy_o` stays high until the ready cycle.
- **Not taken and misaligned.**
  - Not taken: no flush, no redirect.
  - Taken to `0x102`: `misaligned_o` pulses once, no redirect.
  - `stat_resolved_o=2`, `stat_taken_o=1` with the macro defined.
- **Stall and mid-operation reset.**
  - Taken resolution with `ex_stall_i=1` is ignored.
  - `rst_i` in DRAIN returns to IDLE next cycle with all outputs 0.
- **Counter saturation.** With the macro and `STAT_W=4`, 20 accepted resolutions give `stat_resolved_o=15`.
